coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles required to accept a sensor pattern (legal range 2..15).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, number of accepted coins that can be queued (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sense_5  input  1  raw, asynchronous 5-unit coin sensor, high while the coin is present.
REQ-006 SHALL have port sense_10  input  1  raw, asynchronous 10-unit coin sensor, high while the coin is present.
REQ-007 SHALL have port coin_inhibit  input  1  synchronous; when high, no new coin is emitted and queued coins are held.
REQ-008 SHALL have port coin  output  2  registered coin code to vending_machine: 00 none, 01 five, 10 ten; 11 is never driven.
REQ-009 SHALL have port reject  output  1  registered one-cycle pulse on an accepted invalid pattern (both sensors high).
REQ-010 SHALL have port overflow  output  1  registered one-cycle pulse when a valid coin is dropped because the FIFO is full.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued coins.

Function
REQ-012 SHALL pass sense_5 and sense_10 each through a two-flop synchronizer before any other use.
REQ-013 SHALL implement a qualifier FSM with states IDLE, QUAL, WAIT_REL.
REQ-014 IDLE: a nonzero synchronized pattern SHALL move the FSM to QUAL, latch the pattern, and set the stability count to 1.
REQ-015 QUAL, same pattern: the count SHALL increment; on the cycle it reaches DEBOUNCE_CYCLES, the pattern SHALL be accepted and the FSM SHALL go to WAIT_REL.
REQ-016 QUAL, pattern 00 before acceptance: the event SHALL be discarded as a glitch and the FSM SHALL return to IDLE with no output activity.
REQ-017 QUAL, a different nonzero pattern: the new pattern SHALL be latched and the count restarted at 1.
REQ-018 Acceptance: pattern 01 SHALL push code 01, pattern 10 SHALL push code 10, and pattern 11 SHALL pulse reject for one cycle with no push.
REQ-019 WAIT_REL: the FSM SHALL return to IDLE only after both synchronized sensors are low for DEBOUNCE_CYCLES consecutive cycles; any high resets that count, and no new coin is accepted in this state.
REQ-020 A push when fifo_count equals FIFO_DEPTH SHALL drop the coin, pulse overflow for one cycle, and leave the FIFO contents unchanged.
REQ-021 The emitter SHALL pop the FIFO head and drive it on coin for exactly one cycle when the FIFO is non-empty, coin_inhibit is low, and coin was 00 in the current cycle; coin SHALL be 00 in all other cycles.
REQ-022 Consecutive emitted coins SHALL be separated by at least one 00 cycle, giving a maximum rate of one coin per 2 cycles.
REQ-023 Emission order SHALL be FIFO (insertion) order.
REQ-024 On a simultaneous push and pop, both operations SHALL complete and fifo_count SHALL be unchanged; a push to an empty FIFO SHALL NOT be emitted in the same cycle.
REQ-025 Asserting coin_inhibit in the cycle a coin is driven SHALL NOT truncate that pulse.
REQ-026 With the FIFO empty and inhibit low, coin SHALL go high after DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples the sensor high as edge 1.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL immediately force coin=00, reject=0, overflow=0, fifo_count=0, the FSM to IDLE, all counters to 0, and all synchronizer flops to 0.
REQ-029 Reset mid-operation SHALL discard all queued and in-qualification coins; no coin SHALL be emitted for them after reset deasserts.
REQ-030 After reset deasserts, a sensor already held high SHALL be treated as a new event from IDLE.

Verification
REQ-031 sense_5 high for 10 cycles (D=4) -> coin=01 for exactly one cycle at edge 7, then 00; reject=0; overflow=0.
REQ-032 sense_10 high for 3 cycles, then low -> coin stays 00 and fifo_count stays 0.
REQ-033 sense_5 and sense_10 both high for 10 cycles -> reject pulses once for one cycle; coin stays 00.
REQ-034 coin_inhibit high and 5 valid coins inserted (5,10,5,10,5) -> fifo_count=4 and one overflow pulse on the 5th; after inhibit goes low -> coin=01,10,01,10 at a 2-cycle spacing, then fifo_count=0.
REQ-035 2 coins queued under inhibit, with a third in QUAL, then reset pulsed -> all outputs 0 immediately; after inhibit goes low, no coin is emitted.
REQ-036 Sensor bouncing 1-0-1 at release of an accepted coin -> exactly one coin is emitted.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces two coin sensors, queues accepted coins and emits them one per two cycles
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sense_5,
  input  logic                            sense_10,
  input  logic                            coin_inhibit,
  output logic [1:0]                      coin,
  output logic                            reject,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_QUAL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [3:0] D_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_state;
  logic [1:0]    r_pat;
  logic [3:0]    r_cnt;
  logic [1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [1:0]    w_pat;
  logic          w_accept;
  logic          w_push;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;

  assign w_pat    = r_sync2;
  assign w_accept = (r_state == S_QUAL) && (w_pat == r_pat) && (r_cnt == D_LAST);
  assign w_push   = w_accept && (r_pat != 2'b11);
  assign w_full   = (fifo_count == FULL);
  assign w_wr     = w_push && !w_full;
  assign w_rd     = (fifo_count != '0) && !coin_inhibit && (coin == 2'b00);

  // two-flop synchronizers for the raw sensors, bit 1 = ten, bit 0 = five
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {sense_10, sense_5};
      r_sync2 <= r_sync1;
    end
  end

  // qualifier: a pattern must hold for DEBOUNCE_CYCLES, then both sensors must stay low as long before re-arming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pat   <= 2'b00;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_pat != 2'b00) begin
          r_state <= S_QUAL;
          r_pat   <= w_pat;
          r_cnt   <= 4'd1;
        end
        S_QUAL: if (w_pat == 2'b00) begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end else if (w_pat != r_pat) begin
          r_pat <= w_pat;
          r_cnt <= 4'd1;
        end else if (w_accept) begin
          r_state <= S_WAIT;
          r_cnt   <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        S_WAIT: if (w_pat != 2'b00) begin
          r_cnt <= 4'd0;
        end else if (r_cnt == D_LAST) begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  // coin storage; contents need no reset because the pointers and count define validity
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= r_pat;
  end

  // FIFO bookkeeping plus registered coin, reject and overflow outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      fifo_count <= '0;
      coin       <= 2'b00;
      reject     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_wp       <= w_wr ? r_wp + AW'(1) : r_wp;
      r_rp       <= w_rd ? r_rp + AW'(1) : r_rp;
      fifo_count <= fifo_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
      coin       <= w_rd ? r_mem[r_rp] : 2'b00;
      reject     <= w_accept && (r_pat == 2'b11);
      overflow   <= w_push && w_full;
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed and random checks of coin_acceptor against a run-length reference model
module tb_coin_acceptor;
  localparam int D = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sense_5 = 1'b0;
  logic       sense_10 = 1'b0;
  logic       coin_inhibit = 1'b0;
  logic [1:0] coin;
  logic       reject;
  logic       overflow;
  logic [2:0] fifo_count;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .sense_5(sense_5), .sense_10(sense_10),
    .coin_inhibit(coin_inhibit), .coin(coin), .reject(reject),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int seen_rej = 0;
  int seen_ovf = 0;
  int em[$];
  int et[$];

  // reference model: synchronizer delay line, run length of the synchronized pattern, a lock flag and a coin queue
  int  m_s1, m_s2, run_pat, run_len;
  bit  locked;
  int  q[$];
  int  m_coin, m_rej, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; run_pat = 0; run_len = 0; locked = 0;
    q.delete();
    m_coin = 0; m_rej = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int p, old_size, ncoin;
    bit acc, pop;
    p = m_s2;
    m_s2 = m_s1;
    m_s1 = {sense_10, sense_5};
    if (p == run_pat) run_len++;
    else begin
      run_pat = p;
      run_len = 1;
    end
    acc = 0;
    if (locked) begin
      if (run_pat == 0 && run_len == D) locked = 0;
    end else if (run_pat != 0 && run_len == D) begin
      acc = 1;
      locked = 1;
    end
    old_size = q.size();
    pop = old_size > 0 && !coin_inhibit && m_coin == 0;
    ncoin = pop ? q.pop_front() : 0;
    m_rej = acc && run_pat == 3;
    m_ovf = 0;
    if (acc && run_pat != 3) begin
      if (old_size == DEPTH) m_ovf = 1;
      else q.push_back(run_pat);
    end
    m_coin = ncoin;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("coin", coin, m_coin);
    check("reject", reject, m_rej);
    check("overflow", overflow, m_ovf);
    check("fifo_count", fifo_count, q.size());
    if (coin != 2'b00) begin
      em.push_back(coin);
      et.push_back(cyc);
    end
    seen_rej += reject;
    seen_ovf += overflow;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_coin", coin, 0);
    check("rst_reject", reject, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", fifo_count, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_obs();
    em.delete(); et.delete(); seen_rej = 0; seen_ovf = 0;
  endtask

  task automatic hold(input int p, input int n);
    {sense_10, sense_5} = 2'(p);
    repeat (n) tick();
  endtask

  task automatic insert(input int p);
    hold(p, D + 4);
    hold(0, D + 4);
  endtask

  initial begin
    int first;
    pulse_reset();

    // single five coin: first coin edge is D+3
    clear_obs();
    first = 0;
    {sense_10, sense_5} = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (coin == 2'b01 && first == 0) first = i;
    end
    hold(0, 10);
    check("t031_edge", first, D + 3);
    check("t031_coins", em.size(), 1);
    check("t031_rej", seen_rej, 0);

    // short glitch discarded
    clear_obs();
    hold(2, 3);
    hold(0, 10);
    check("t032_coins", em.size(), 0);
    check("t032_count", fifo_count, 0);

    // both sensors -> one reject, no coin
    clear_obs();
    hold(3, 10);
    hold(0, 10);
    check("t033_rej", seen_rej, 1);
    check("t033_coins", em.size(), 0);

    // overflow under inhibit, then drain in order at 2-cycle spacing
    clear_obs();
    coin_inhibit = 1'b1;
    insert(1); insert(2); insert(1); insert(2); insert(1);
    check("t034_count", fifo_count, DEPTH);
    check("t034_ovf", seen_ovf, 1);
    coin_inhibit = 1'b0;
    repeat (12) tick();
    check("t034_n", em.size(), 4);
    if (em.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t034_code", em[i], (i % 2 == 0) ? 1 : 2);
      for (int i = 1; i < 4; i++) check("t034_gap", et[i] - et[i-1], 2);
    end
    check("t034_empty", fifo_count, 0);

    // reset discards queued and qualifying coins
    clear_obs();
    coin_inhibit = 1'b1;
    insert(1); insert(2);
    hold(1, 4);
    check("t035_pre", fifo_count, 2);
    {sense_10, sense_5} = 2'b00;
    pulse_reset();
    coin_inhibit = 1'b0;
    repeat (20) tick();
    check("t035_coins", em.size(), 0);

    // bounce at release gives one coin
    clear_obs();
    hold(1, 8); hold(0, 1); hold(1, 1); hold(0, 1); hold(1, 1);
    hold(0, 12);
    check("t036_coins", em.size(), 1);

    // sensor held through reset is a new event afterwards
    clear_obs();
    {sense_10, sense_5} = 2'b10;
    repeat (3) tick();
    pulse_reset();
    hold(2, 10);
    hold(0, 10);
    check("t030_coins", em.size(), 1);

    // random soak
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) coin_inhibit = ~coin_inhibit;
      if ($urandom_range(0, 79) == 0) pulse_reset();
      hold($urandom_range(0, 3), $urandom_range(1, 9));
    end
    coin_inhibit = 1'b0;
    hold(0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
